// File: rtl/attractor_logger.sv
// Logs the outcome of each gene-network run (fixed point, cycle or timeout) into a
// first-word fall-through record FIFO with sticky overflow and drop counting.
module attractor_logger #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  MAX_STEPS  = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] init_val,
  input  logic [7:0] x,
  input  logic       fixed_flag,
  input  logic       cycle_flag,
  input  logic       rec_ready,
  output logic       rec_valid,
  output logic [7:0] rec_init,
  output logic [7:0] rec_state,
  output logic [1:0] rec_type,
  output logic [7:0] rec_steps,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = 26;

  localparam logic [1:0] TypeFixed   = 2'b00;
  localparam logic [1:0] TypeCycle   = 2'b01;
  localparam logic [1:0] TypeTimeout = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPush = 2'd2
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;

  logic [7:0]    r_init;
  logic [7:0]    r_step_cnt;
  logic [7:0]    w_step_inc;
  logic [7:0]    r_cap_state;
  logic [7:0]    r_cap_steps;
  logic [1:0]    r_cap_type;
  logic          w_load;
  logic          w_capture;
  logic [1:0]    w_cap_type;

  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic [RW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [RW-1:0] w_head;

  // Count including the current RUN cycle, i.e. cycles elapsed since the start edge.
  assign w_step_inc = (r_step_cnt >= MAX_STEPS) ? MAX_STEPS : r_step_cnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_cap_type  = TypeFixed;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (start) begin
          w_load      = 1'b1;
        end else if (fixed_flag) begin
          w_capture   = 1'b1;
          w_cap_type  = TypeFixed;
          w_state_nxt = StPush;
        end else if (cycle_flag) begin
          w_capture   = 1'b1;
          w_cap_type  = TypeCycle;
          w_state_nxt = StPush;
        end else if (w_step_inc == MAX_STEPS) begin
          w_capture   = 1'b1;
          w_cap_type  = TypeTimeout;
          w_state_nxt = StPush;
        end
      end
      StPush: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = StRun;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_init      <= 8'd0;
      r_step_cnt  <= 8'd0;
      r_cap_state <= 8'd0;
      r_cap_steps <= 8'd0;
      r_cap_type  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_init     <= init_val;
        r_step_cnt <= 8'd0;
      end else if (r_state == StRun) begin
        r_step_cnt <= w_step_inc;
      end
      if (w_capture) begin
        r_cap_state <= x;
        r_cap_type  <= w_cap_type;
        r_cap_steps <= w_step_inc;
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && rec_ready;
  // A full FIFO still accepts the record if the head leaves in the same cycle.
  assign w_push  = (r_state == StPush) && (!w_full || w_pop);
  assign w_drop  = (r_state == StPush) && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_init, r_cap_state, r_cap_type, r_cap_steps};
    end
  end

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign rec_valid = !w_empty;
  // Outputs read zero when nothing is queued, which also covers the reset state.
  assign {rec_init, rec_state, rec_type, rec_steps} = rec_valid ? w_head : '0;
  assign busy      = (r_state != StIdle);
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_attractor_logger.sv
// Self-checking bench for attractor_logger: directed scenarios plus random traffic,
// all compared against a run/queue-level reference model.
module tb_attractor_logger;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  MAXS  = 8'd255;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] init_val;
  logic [7:0] x;
  logic       fixed_flag;
  logic       cycle_flag;
  logic       rec_ready;
  logic       rec_valid;
  logic [7:0] rec_init;
  logic [7:0] rec_state;
  logic [1:0] rec_type;
  logic [7:0] rec_steps;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  attractor_logger #(
    .FIFO_DEPTH(DEPTH),
    .MAX_STEPS (MAXS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .init_val  (init_val),
    .x         (x),
    .fixed_flag(fixed_flag),
    .cycle_flag(cycle_flag),
    .rec_ready (rec_ready),
    .rec_valid (rec_valid),
    .rec_init  (rec_init),
    .rec_state (rec_state),
    .rec_type  (rec_type),
    .rec_steps (rec_steps),
    .busy      (busy),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: runs, a pending record and a record queue
  typedef struct packed {
    logic [7:0] init;
    logic [7:0] st;
    logic [1:0] typ;
    logic [7:0] steps;
  } rec_t;

  rec_t       m_q[$];
  rec_t       m_pend_rec;
  bit         m_pend   = 0;
  bit         m_active = 0;
  bit         m_over   = 0;
  int         m_drop   = 0;
  int         m_cyc    = 0;
  int         m_start  = 0;
  logic [7:0] m_init   = 8'd0;

  task automatic model_step();
    int k;
    m_cyc++;
    if (rst) begin
      m_q.delete();
      m_pend   = 0;
      m_active = 0;
      m_over   = 0;
      m_drop   = 0;
    end else begin
      if (m_q.size() != 0 && rec_ready) m_q.delete(0);
      if (m_pend) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pend_rec);
        else begin
          m_over = 1;
          if (m_drop < 255) m_drop++;
        end
        m_pend = 0;
      end
      if (m_active) begin
        k = m_cyc - m_start;
        if (start) begin
          m_start = m_cyc;
          m_init  = init_val;
        end else if (fixed_flag || cycle_flag || k == int'(MAXS)) begin
          m_pend_rec.init  = m_init;
          m_pend_rec.st    = x;
          m_pend_rec.typ   = fixed_flag ? 2'b00 : (cycle_flag ? 2'b01 : 2'b10);
          m_pend_rec.steps = 8'(k);
          m_pend   = 1;
          m_active = 0;
        end
      end else if (start) begin
        m_active = 1;
        m_start  = m_cyc;
        m_init   = init_val;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [26:0] exp_vec();
    if (m_q.size() == 0) return 27'd0;
    return {1'b1, m_q[0]};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {rec_valid, rec_init, rec_state, rec_type, rec_steps};
  endfunction

  // ---------------- stimulus helpers (no checking)
  task automatic tick();
    @(negedge clk);
  endtask

  // Start a run and raise the given flags so they are sampled d cycles after start.
  // Returns at the negedge of the PUSH cycle.
  task automatic do_run(input logic [7:0] iv, input logic [7:0] xv,
                        input bit f, input bit c, input int d);
    start = 1'b1; init_val = iv;
    tick();
    start = 1'b0;
    repeat (d - 1) tick();
    x = xv; fixed_flag = f; cycle_flag = c;
    tick();
    fixed_flag = 1'b0; cycle_flag = 1'b0;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; fixed_flag = 1'b1; cycle_flag = 1'b1; rec_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({dut_vec(), busy, overflow, drop_cnt} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vec=%h busy=%b ovf=%b drop=%0d expected all zero",
               dut_vec(), busy, overflow, drop_cnt);
    end
    start = 1'b0; fixed_flag = 1'b0; cycle_flag = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({rec_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b busy=%b expected 0 0", rec_valid, busy);
    end
  endtask

  task automatic test_fixed_point();
    do_run(8'h1A, 8'h3C, 1'b1, 1'b0, 5);
    n_cmp++;
    if ({rec_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL fixed_push_cycle: got valid=%b busy=%b expected 0 1", rec_valid, busy);
    end
    tick();
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'h1A, 8'h3C, 2'b00, 8'd5}) begin
      n_fail++;
      $display("FAIL fixed_record: got %h expected %h", dut_vec(),
               {1'b1, 8'h1A, 8'h3C, 2'b00, 8'd5});
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_idle: got busy=%b expected 0", busy);
    end
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    n_cmp++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_pop: got valid=%b expected 0", rec_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] iv, xv;
    iv = 8'($urandom); xv = 8'($urandom);
    do_run(iv, xv, 1'b1, 1'b1, int'($urandom_range(1, 10)));
    tick();
    n_cmp++;
    if (rec_type !== 2'b00 || rec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_type: got valid=%b type=%b expected 1 00", rec_valid, rec_type);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL simul_record: got %h expected %h", dut_vec(), exp_vec());
    end
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] iv;
    iv = 8'($urandom);
    start = 1'b1; init_val = iv;
    tick();
    start = 1'b0;
    n = 0;
    while (rec_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 256) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles expected 256", n);
    end
    n_cmp++;
    if (dut_vec() !== {1'b1, iv, x, 2'b10, 8'd255}) begin
      n_fail++;
      $display("FAIL timeout_record: got %h expected %h", dut_vec(),
               {1'b1, iv, x, 2'b10, 8'd255});
    end
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
  endtask

  task automatic test_overflow();
    rec_t exp_recs[5];
    for (int i = 0; i < 5; i++) begin
      int d;
      bit f;
      d = int'($urandom_range(1, 12));
      f = 1'($urandom);
      exp_recs[i].init  = 8'($urandom);
      exp_recs[i].st    = 8'($urandom);
      exp_recs[i].typ   = f ? 2'b00 : 2'b01;
      exp_recs[i].steps = 8'(d);
      do_run(exp_recs[i].init, exp_recs[i].st, f, !f, d);
      tick();
    end
    n_cmp++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL ovf_flags: got ovf=%b drop=%0d expected 1 1", overflow, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut_vec() !== {1'b1, exp_recs[i]}) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d: got %h expected %h", i, dut_vec(), {1'b1, exp_recs[i]});
      end
      rec_ready = 1'b1;
      tick();
    end
    rec_ready = 1'b0;
    n_cmp++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_empty: got valid=%b expected 0", rec_valid);
    end
  endtask

  task automatic test_restart();
    logic [7:0] xv;
    xv = 8'($urandom);
    rec_ready = 1'b1;
    start = 1'b1; init_val = 8'($urandom);
    tick();
    start = 1'b0;
    repeat (3) tick();
    do_run(8'h77, xv, 1'b0, 1'b1, 3);
    n_cmp++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_no_record: got valid=%b expected 0", rec_valid);
    end
    tick();
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'h77, xv, 2'b01, 8'd3}) begin
      n_fail++;
      $display("FAIL restart_record: got %h expected %h", dut_vec(),
               {1'b1, 8'h77, xv, 2'b01, 8'd3});
    end
    tick();
    n_cmp++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_single: got valid=%b expected 0", rec_valid);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_reset_mid_push();
    do_run(8'($urandom), 8'($urandom), 1'b1, 1'b0, 2);
    tick();
    do_run(8'($urandom), 8'($urandom), 1'b0, 1'b1, 3);
    tick();
    do_run(8'($urandom), 8'($urandom), 1'b1, 1'b0, 4);
    n_cmp++;
    if ({rec_valid, busy, overflow} !== 3'b111) begin
      n_fail++;
      $display("FAIL midpush_pre: got valid=%b busy=%b ovf=%b expected 1 1 1",
               rec_valid, busy, overflow);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({rec_valid, busy, overflow, drop_cnt} !== 11'd0) begin
      n_fail++;
      $display("FAIL midpush_reset: got valid=%b busy=%b ovf=%b drop=%0d expected 0 0 0 0",
               rec_valid, busy, overflow, drop_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      n_cmp++;
      if ({dut_vec(), busy, overflow, drop_cnt} !==
          {exp_vec(), (m_active || m_pend), m_over, 8'(m_drop)}) begin
        n_fail++;
        $display("FAIL random_c%0d: got vec=%h busy=%b ovf=%b drop=%0d expected vec=%h busy=%b ovf=%b drop=%0d",
                 c, dut_vec(), busy, overflow, drop_cnt, exp_vec(), (m_active || m_pend),
                 m_over, m_drop);
      end
      start      = ($urandom_range(0, 9) == 0);
      init_val   = 8'($urandom);
      x          = 8'($urandom);
      fixed_flag = ($urandom_range(0, 6) == 0);
      cycle_flag = ($urandom_range(0, 6) == 0);
      rec_ready  = ($urandom_range(0, 2) == 0);
      tick();
    end
    start = 1'b0; fixed_flag = 1'b0; cycle_flag = 1'b0; rec_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; init_val = 8'd0; x = 8'd0;
    fixed_flag = 1'b0; cycle_flag = 1'b0; rec_ready = 1'b0;
    tick();
    test_reset();
    test_fixed_point();
    test_simultaneous();
    test_timeout();
    test_overflow();
    test_restart();
    test_reset_mid_push();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
